// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, coordinate type and decode helper
package vga_timing_pkg;

  // Default 640x480@60 Hz raster geometry
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  // Mapper ROM + register latency that sync must match
  localparam int VGA_PIPE_DLY  = 2;

  // Derived totals and sync window bounds (start inclusive, end exclusive)
  localparam int VGA_H_TOTAL      = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  typedef logic [9:0] coord_t;

  // 11-bit compare so a window ending exactly at 1024 still decodes correctly
  function automatic logic in_window(input coord_t v, input logic [10:0] lo,
                                     input logic [10:0] hi);
    logic [10:0] ext;
    ext = {1'b0, v};
    return (ext >= lo) && (ext < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - free-running shift register aligning sync with the mapper pipeline
module sync_delay_line #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    // Zero depth: no stages, the input is the output
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_n_i;
    assign q_o = d_i;
  end else begin : g_stages
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift every clock; reset flushes every stage to the idle value
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, visible/sync decode, strobes and frame counter
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int PIPE_DLY  = VGA_PIPE_DLY
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Counters are 10 bits wide, so a larger raster cannot be represented
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  localparam coord_t      H_LAST     = coord_t'(H_TOT - 1);
  localparam coord_t      V_LAST     = coord_t'(V_TOT - 1);
  localparam logic [10:0] H_VIS_C    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_C    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START_C = 11'(HS_START);
  localparam logic [10:0] HS_END_C   = 11'(HS_END);
  localparam logic [10:0] VS_START_C = 11'(VS_START);
  localparam logic [10:0] VS_END_C   = 11'(VS_END);

  coord_t      x_q, x_d;
  coord_t      y_q, y_d;
  logic        x_wrap, y_wrap;
  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        line_start_q;
  logic        frame_start_q;
  logic [15:0] frame_cnt_q;
  logic [1:0]  sync_dly;

  // Next raster position and the decodes of that position, so the registered
  // decodes land on the same edge as the counters they describe
  always_comb begin
    x_wrap  = (x_q == H_LAST);
    y_wrap  = (y_q == V_LAST);
    x_d     = x_wrap ? '0 : x_q + 10'd1;
    y_d     = y_q;
    if (x_wrap) begin
      y_d = y_wrap ? '0 : y_q + 10'd1;
    end
    blank_d = ({1'b0, x_d} < H_VIS_C) && ({1'b0, y_d} < V_VIS_C);
    hs_d    = !in_window(x_d, HS_START_C, HS_END_C);
    vs_d    = !in_window(y_d, VS_START_C, VS_END_C);
  end

  // Counter, decode, strobe and frame-count registers; ce gates stepping,
  // strobes are recomputed every clock so they stay one clock wide
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      line_start_q  <= ce && x_wrap;
      frame_start_q <= ce && x_wrap && y_wrap;
      if (ce) begin
        x_q     <= x_d;
        y_q     <= y_d;
        blank_q <= blank_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        if (x_wrap && y_wrap) begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
      end
    end
  end

  // Sync delayed to match mapper RGB latency; runs every clock, not ce-gated
  sync_delay_line #(
    .DEPTH     (PIPE_DLY),
    .WIDTH     (2),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .clk_i   (vga_clk),
    .rst_n_i (reset_n),
    .d_i     ({hs_q, vs_q}),
    .q_o     (sync_dly)
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = sync_dly[1];
  assign vs          = sync_dly[0];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks on a full-size and a reduced-geometry instance
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full 640x480 instance, PIPE_DLY=2
  logic        rst_n, ce;
  logic [9:0]  dx, dy;
  logic        blank, hs, vs, ls, fs;
  logic [15:0] fc;

  // Reduced 16x11 raster, PIPE_DLY=0, so whole frames fit in a short run
  // H: 8 visible, fp 2, sync 3 (X 10..12), bp 3 ; V: 6 visible, fp 1, sync 2 (Y 7..8), bp 2
  logic        rst_s_n, ce_s;
  logic [9:0]  dx_s, dy_s;
  logic        blank_s, hs_s, vs_s, ls_s, fs_s;
  logic [15:0] fc_s;

  int errs   = 0;
  int checks = 0;
  int n;

  vga_timing_gen #(.PIPE_DLY(2)) dut (
    .vga_clk(clk), .reset_n(rst_n), .ce(ce),
    .DrawX(dx), .DrawY(dy), .blank(blank), .hs(hs), .vs(vs),
    .line_start(ls), .frame_start(fs), .frame_cnt(fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PIPE_DLY(0)
  ) dut_s (
    .vga_clk(clk), .reset_n(rst_s_n), .ce(ce_s),
    .DrawX(dx_s), .DrawY(dy_s), .blank(blank_s), .hs(hs_s), .vs(vs_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1;
    rst_s_n = 1'b0; ce_s = 1'b1;

    // ---------------- full-size instance ----------------
    tick();
    check_eq("rst_x", dx, 0);
    check_eq("rst_y", dy, 0);
    check_eq("rst_blank", blank, 0);
    check_eq("rst_hs", hs, 1);
    check_eq("rst_vs", vs, 1);
    check_eq("rst_ls", ls, 0);
    check_eq("rst_fs", fs, 0);
    check_eq("rst_fc", fc, 0);

    rst_n = 1'b1;
    tick();
    check_eq("x_first", dx, 1);
    check_eq("blank_1_0", blank, 1);
    ticks(638);
    check_eq("x_639", dx, 639);
    check_eq("blank_639_0", blank, 1);
    tick();
    check_eq("blank_640_0", blank, 0);

    ticks(16);
    check_eq("x_656", dx, 656);
    check_eq("hs_656_dly", hs, 1);
    tick();
    check_eq("hs_657_dly", hs, 1);
    tick();
    check_eq("hs_658_low", hs, 0);
    ticks(95);
    check_eq("hs_753_low", hs, 0);
    tick();
    check_eq("hs_754_high", hs, 1);

    ticks(45);
    check_eq("x_799", dx, 799);
    tick();
    check_eq("wrap_x", dx, 0);
    check_eq("wrap_y", dy, 1);
    check_eq("wrap_ls", ls, 1);
    check_eq("wrap_fs", fs, 0);
    check_eq("blank_0_1", blank, 1);
    check_eq("vs_idle", vs, 1);

    n = 0;
    do begin tick(); n++; end while (!ls && n < 2000);
    check_eq("line_period", n, 800);
    check_eq("line2_y", dy, 2);

    // ce alternating 0,1,0,1: line period doubles
    n = 0;
    do begin ce = n[0]; tick(); n++; end while (!ls && n < 4000);
    check_eq("line_period_ce", n, 1600);
    check_eq("line3_y", dy, 3);
    ce = 1'b0; tick();
    check_eq("ls_width_ce", ls, 0);
    check_eq("hold_x0", dx, 0);
    ce = 1'b1; tick();
    check_eq("step_x1", dx, 1);
    ce = 1'b0; tick();
    check_eq("hold_x1", dx, 1);
    ce = 1'b1;

    // Reset while hs is low in the delay line
    ticks(699);
    check_eq("x_700", dx, 700);
    check_eq("hs_700_low", hs, 0);
    rst_n = 1'b0; tick();
    check_eq("mid_rst_x", dx, 0);
    check_eq("mid_rst_y", dy, 0);
    check_eq("mid_rst_blank", blank, 0);
    check_eq("mid_rst_hs", hs, 1);
    check_eq("mid_rst_fc", fc, 0);
    rst_n = 1'b1;

    // ---------------- reduced instance ----------------
    tick();
    check_eq("s_rst_x", dx_s, 0);
    check_eq("s_rst_blank", blank_s, 0);
    check_eq("s_rst_fc", fc_s, 0);
    rst_s_n = 1'b1;

    n = 0;
    do begin tick(); n++; end while (!fs_s && n < 1000);
    check_eq("s_frame_period", n, 176);
    check_eq("s_f1_x", dx_s, 0);
    check_eq("s_f1_y", dy_s, 0);
    check_eq("s_f1_ls", ls_s, 1);
    check_eq("s_f1_fc", fc_s, 1);
    check_eq("s_blank_0_0_f2", blank_s, 1);
    tick();
    check_eq("s_fs_width", fs_s, 0);

    ticks(8);
    check_eq("s_hs_9", hs_s, 1);
    check_eq("s_blank_9_0", blank_s, 0);
    tick();
    check_eq("s_hs_10_nodly", hs_s, 0);
    ticks(3);
    check_eq("s_hs_13", hs_s, 1);

    ticks(74);
    check_eq("s_blank_7_5", blank_s, 1);
    tick();
    check_eq("s_blank_8_5", blank_s, 0);
    ticks(8);
    check_eq("s_y6", dy_s, 6);
    check_eq("s_blank_0_6", blank_s, 0);
    ticks(15);
    check_eq("s_vs_15_6", vs_s, 1);
    tick();
    check_eq("s_vs_0_7", vs_s, 0);
    ticks(31);
    check_eq("s_vs_15_8", vs_s, 0);
    tick();
    check_eq("s_vs_0_9", vs_s, 1);

    n = 0;
    do begin tick(); n++; end while (!fs_s && n < 1000);
    check_eq("s_f2_dist", n, 32);
    check_eq("s_f2_fc", fc_s, 2);
    n = 0;
    do begin tick(); n++; end while (!fs_s && n < 1000);
    check_eq("s_f3_period", n, 176);
    check_eq("s_f3_fc", fc_s, 3);

    ticks(123);
    check_eq("s_pre_rst_hs", hs_s, 0);
    check_eq("s_pre_rst_vs", vs_s, 0);
    rst_s_n = 1'b0; tick();
    check_eq("s_mid_rst_x", dx_s, 0);
    check_eq("s_mid_rst_y", dy_s, 0);
    check_eq("s_mid_rst_hs", hs_s, 1);
    check_eq("s_mid_rst_vs", vs_s, 1);
    check_eq("s_mid_rst_fc", fc_s, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the 640x480@60 Hz raster: pixel/line counters, DrawX/DrawY, blank, hs, vs.
- Drives every sprite/background mapper. Mappers consume DrawX, DrawY and blank, then present RGB after a fixed 2-clock ROM + register pipeline.
- hs/vs leave this block delayed by the same depth, so sync stays aligned with mapper RGB at the connector.
- Also provides frame/line strobes and a frame counter for game logic.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_DLY, 2, vga_clk cycles of delay applied to hs/vs (matches mapper latency); 0 allowed

Ports:
vga_clk  input  1  pixel-domain clock
reset_n  input  1  synchronous active-low reset
ce  input  1  pixel advance enable; counters step only on ce=1 cycles
DrawX  output  10  current pixel column (h counter)
DrawY  output  10  current line (v counter)
blank  output  1  1 = current (DrawX,DrawY) is visible; aligned with DrawX/DrawY
hs  output  1  horizontal sync, active low, delayed PIPE_DLY clocks
vs  output  1  vertical sync, active low, delayed PIPE_DLY clocks
line_start  output  1  one-vga_clk pulse when DrawX wraps to 0
frame_start  output  1  one-vga_clk pulse when (DrawX,DrawY) wraps to (0,0)
frame_cnt  output  16  frames completed since reset, wraps modulo 2^16

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be <=1024; elaboration error otherwise.
- Reset (reset_n=0 at a vga_clk edge, any ce):
  - DrawX=0, DrawY=0, blank=0.
  - Internal hs/vs=1; every delay-line stage=1, so hs=vs=1 on the next cycle.
  - line_start=0, frame_start=0, frame_cnt=0.
  - Reset mid-frame takes effect on that edge; no partial-frame completion.
- Counter step on each edge with reset_n=1, ce=1:
  - DrawX <= DrawX+1, or 0 when DrawX=H_TOTAL-1.
  - DrawY increments when DrawX wraps, wrapping to 0 at V_TOTAL-1.
  - ce=0: all counters and registered decodes hold; delay line still shifts.
- Registered decodes, computed from the next counter values so they stay coincident with DrawX/DrawY:
  - blank=1 iff nextX<H_VISIBLE and nextY<V_VISIBLE.
  - internal hs=0 iff H_VISIBLE+H_FP <= nextX < H_VISIBLE+H_FP+H_SYNC (656..751).
  - internal vs=0 iff V_VISIBLE+V_FP <= nextY < V_VISIBLE+V_FP+V_SYNC (490..491).
- First frame after reset: pixel (0,0) shows blank=0. Counters leave (0,0) on the first ce edge; from there decode is exact.
- line_start / frame_start:
  - Asserted for exactly one vga_clk on the ce edge that wraps DrawX (resp. both counters), regardless of ce duty.
  - frame_start implies line_start.
- frame_cnt increments on the same edge frame_start asserts.
- Delay line: PIPE_DLY-stage shift register on hs and vs, clocked every vga_clk (not ce-gated). PIPE_DLY=0 passes the internal regs straight through.
- Latency: DrawX/DrawY/blank/strobes change on the ce edge; hs/vs follow PIPE_DLY clocks later.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480 timing constants (defaults above);
  - derived H_TOTAL/V_TOTAL and sync start/end localparams;
  - coord_t (logic [9:0]).
- One sub-module: sync_delay_line (parameters DEPTH, WIDTH, RESET_VAL); synchronous active-low reset; used for {hs,vs}.

Test Plan:
1. Reset, ce=1 continuous -> DrawX runs 1..799,0; line_start every 800 clocks; frame_start every 420000 clocks, coincident with DrawX=0,DrawY=0.
2. Sync timing, PIPE_DLY=2 -> hs falls 2 clocks after DrawX becomes 656 and stays low 96 clocks; vs low during DrawY=490..491 (1600 clocks), shifted 2 clocks.
3. Blank decode -> blank=1 at (639,479), 0 at (640,0), 0 at (0,480), 1 at (0,0) of the second frame.
4. ce toggling 1,0,1,0 -> each counter value held 2 clocks; line period 1600 clocks; line_start/frame_start remain 1 clock wide.
5. Assert reset_n=0 for one edge at DrawX=300,DrawY=200 -> next cycle DrawX=0, DrawY=0, blank=0, frame_cnt=0; hs=vs=1 through the flushed delay line.
6. Run 3 full frames -> frame_cnt steps 0->1->2->3, each increment on the frame_start edge; PIPE_DLY=0 build shows hs falling on the same edge DrawX becomes 656.
